oq_rr_input_arbiter: RTL and testbench

- Packet-granular round-robin arbiter in front of the output-queue stage.
- Merges NUM_QUEUES first-word-fall-through (FWFT) requester FIFOs into the single 64-bit data/ctrl stream that feeds the output queues.
- A grant is held from the first module-header word through the end-of-packet (EOP) word, so packets are never interleaved.
- Also sequences reads: it pops source FIFOs only when the downstream stage signals ready.

---
 rtl/oq_rr_input_arbiter.sv | 129 ++++++++++++
 tb/tb_oq_rr_input_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oq_rr_input_arbiter.sv
// Packet-granular round-robin merge of NUM_QUEUES FWFT FIFOs into one data/ctrl stream.
// Define OQ_ARB_STRICT_PRIO_EN to replace round-robin with strict lowest-index priority.
module oq_rr_input_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_QUEUES = 4,
  parameter int QSEL_WIDTH = $clog2(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_empty,
  output logic [NUM_QUEUES-1:0]            in_rd_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [QSEL_WIDTH-1:0]            grant,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t                  state;
  logic [QSEL_WIDTH-1:0]   scan_start;
  logic [QSEL_WIDTH-1:0]   next_sel;
  logic                    found;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [CTRL_WIDTH-1:0]   head_ctrl;
  logic                    pop;
  logic                    grant_is_last;

`ifdef OQ_ARB_STRICT_PRIO_EN
  assign scan_start = '0;
`else
  logic [QSEL_WIDTH-1:0]   rr_ptr;
  assign scan_start = rr_ptr;
`endif

  assign grant_is_last = (grant == QSEL_WIDTH'(NUM_QUEUES - 1));

  // Wrapping scan from scan_start; subtract instead of masking so non-power-of-two counts work.
  always_comb begin
    int idx;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    idx      = 0;
    found    = 1'b0;
    next_sel = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      idx = int'(scan_start) + k;
      if (idx >= NUM_QUEUES) idx -= NUM_QUEUES;
      if (!found && !in_empty[idx]) begin
        found    = 1'b1;
        next_sel = QSEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    head_data = '0;
    head_ctrl = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (grant == QSEL_WIDTH'(i)) begin
        head_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        head_ctrl = in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end
  end

  // Only the granted queue is ever popped, and never in IDLE (the per-packet bubble).
  always_comb begin
    in_rd_en = '0;
    if (state != IDLE && out_rdy) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (grant == QSEL_WIDTH'(i)) in_rd_en[i] = !in_empty[i];
      end
    end
  end

  assign pop = |in_rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
`ifdef OQ_ARB_STRICT_PRIO_EN
`else
      rr_ptr   <= '0;
`endif
    end else begin
      out_wr <= pop;
      if (pop) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
      case (state)
        IDLE: begin
          if (found) begin
            grant <= next_sel;
            busy  <= 1'b1;
            state <= HDR;
          end
        end
        HDR: begin
          if (pop && head_ctrl == '0) state <= PAYLOAD;
        end
        PAYLOAD: begin
          // Non-zero ctrl after payload marks EOP and releases the grant.
          if (pop && head_ctrl != '0) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef OQ_ARB_STRICT_PRIO_EN
`else
            rr_ptr <= grant_is_last ? '0 : grant + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oq_rr_input_arbiter.sv
// Self-checking bench for oq_rr_input_arbiter: FIFO models, stream scoreboard, vector table, random runs.
// Expectations follow OQ_ARB_STRICT_PRIO_EN when it is defined for the build.
module tb_oq_rr_input_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int QW = 2;
`ifdef OQ_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } word_t;

  typedef struct packed {
    logic [N-1:0]  empty;
    logic          rdy;
    logic          exp_busy;
    logic [QW-1:0] exp_grant;
    logic [N-1:0]  exp_rd;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*DW-1:0] in_data = '0;
  logic [N*CW-1:0] in_ctrl = '0;
  logic [N-1:0]    in_empty = '1;
  logic [N-1:0]    in_rd_en;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic            out_wr;
  logic            out_rdy = 1'b0;
  logic [QW-1:0]   grant;
  logic            busy;

  oq_rr_input_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(N), .QSEL_WIDTH(QW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .out_wr   (out_wr),
    .out_rdy  (out_rdy),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  word_t fifo_q [N][$];
  word_t tmp_q  [N][$];
  word_t exp_q  [$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t mk(input logic [CW-1:0] c, input logic [DW-1:0] d);
    word_t w;
    w.ctrl = c;
    w.data = d;
    return w;
  endfunction

  // Present each FIFO head the way an FWFT FIFO would, then let comb logic settle.
  task automatic apply();
    for (int i = 0; i < N; i++) begin
      in_empty[i] = (fifo_q[i].size() == 0);
      if (fifo_q[i].size() != 0) begin
        in_ctrl[i*CW +: CW] = fifo_q[i][0].ctrl;
        in_data[i*DW +: DW] = fifo_q[i][0].data;
      end
    end
    #1;
  endtask

  // One clock: capture pops before the edge, retire them after it, score any write.
  task automatic step();
    logic [N-1:0] pops;
    word_t        got;
    word_t        want;
    #1;
    pops = in_rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pops[i] === 1'b1) begin
        check($sformatf("pop_nonempty_q%0d", i), 72'(fifo_q[i].size() != 0), 72'd1);
        if (fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
      end
    end
    if (mon_en && out_wr === 1'b1) begin
      got = {out_ctrl, out_data};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got %0h expected no write at %0t", got, $time);
      end else begin
        want = exp_q.pop_front();
        check("stream_word", got, want);
      end
    end
    apply();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    out_rdy = 1'b0;
    mon_en  = 1'b0;
    step();
    for (int i = 0; i < N; i++) fifo_q[i].delete();
    exp_q.delete();
    reset = 1'b0;
    apply();
  endtask

  task automatic push_pkt(input int q, input int p, input int nh, input int np);
    int idx;
    idx = 0;
    for (int h = 0; h < nh; h++) begin
      fifo_q[q].push_back(mk(8'hFF, {8'(q), 8'(p), 16'(idx), 32'hC0DE_0000 + 32'(idx)}));
      idx++;
    end
    for (int k = 0; k < np; k++) begin
      fifo_q[q].push_back(mk(8'h00, {8'(q), 8'(p), 16'(idx), 32'hC0DE_0000 + 32'(idx)}));
      idx++;
    end
    fifo_q[q].push_back(mk(8'h01, {8'(q), 8'(p), 16'(idx), 32'hC0DE_0000 + 32'(idx)}));
  endtask

  // Reference: whole packets leave in arbitration order; a packet ends at the first
  // non-zero ctrl that follows a zero-ctrl word.
  task automatic build_expected(input int start);
    int    ptr;
    int    sel;
    bit    seen_payload;
    word_t w;
    for (int i = 0; i < N; i++) tmp_q[i] = fifo_q[i];
    ptr = start;
    forever begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && tmp_q[(ptr + k) % N].size() != 0) sel = (ptr + k) % N;
      end
      if (sel < 0) break;
      seen_payload = 1'b0;
      while (tmp_q[sel].size() != 0) begin
        w = tmp_q[sel].pop_front();
        exp_q.push_back(w);
        if (w.ctrl == '0) seen_payload = 1'b1;
        else if (seen_payload) break;
      end
      ptr = STRICT ? 0 : (sel + 1) % N;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, 72'(exp_q.size()), 72'd0);
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    vec_t v;
    int   n;

    vecs[0] = '{empty: 4'b1111, rdy: 1'b1, exp_busy: 1'b0, exp_grant: 2'd0, exp_rd: 4'b0000};
    vecs[1] = '{empty: 4'b1110, rdy: 1'b1, exp_busy: 1'b1, exp_grant: 2'd0, exp_rd: 4'b0001};
    vecs[2] = '{empty: 4'b1101, rdy: 1'b1, exp_busy: 1'b1, exp_grant: 2'd1, exp_rd: 4'b0010};
    vecs[3] = '{empty: 4'b1011, rdy: 1'b0, exp_busy: 1'b1, exp_grant: 2'd2, exp_rd: 4'b0000};
    vecs[4] = '{empty: 4'b0111, rdy: 1'b1, exp_busy: 1'b1, exp_grant: 2'd3, exp_rd: 4'b1000};
    vecs[5] = '{empty: 4'b1010, rdy: 1'b1, exp_busy: 1'b1, exp_grant: 2'd0, exp_rd: 4'b0001};
    vecs[6] = '{empty: 4'b0011, rdy: 1'b1, exp_busy: 1'b1, exp_grant: 2'd2, exp_rd: 4'b0100};
    vecs[7] = '{empty: 4'b1001, rdy: 1'b0, exp_busy: 1'b1, exp_grant: 2'd1, exp_rd: 4'b0000};
    vecs[8] = '{empty: 4'b0000, rdy: 1'b1, exp_busy: 1'b1, exp_grant: 2'd0, exp_rd: 4'b0001};

    // Reset state, then 20 idle cycles with nothing to serve.
    step();
    step();
    reset   = 1'b0;
    out_rdy = 1'b1;
    apply();
    check("rst_out_data", 72'(out_data), 72'd0);
    check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
    check("rst_grant", 72'(grant), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_out_wr", 72'(out_wr), 72'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      check("idle_out_wr", 72'(out_wr), 72'd0);
      check("idle_busy", 72'(busy), 72'd0);
      check("idle_rd_en", 72'(in_rd_en), 72'd0);
    end

    // First arbitration after reset: pointer is 0 in both builds.
    for (int t = 0; t < 9; t++) begin
      v = vecs[t];
      do_reset();
      for (int i = 0; i < N; i++) begin
        if (!v.empty[i]) fifo_q[i].push_back(mk(8'hFF, 64'(i)));
      end
      out_rdy = v.rdy;
      apply();
      step();
      check($sformatf("tbl%0d_busy", t), 72'(busy), 72'(v.exp_busy));
      check($sformatf("tbl%0d_grant", t), 72'(grant), 72'(v.exp_grant));
      check($sformatf("tbl%0d_rd_en", t), 72'(in_rd_en), 72'(v.exp_rd));
    end

    // Single packet on q2: 2 headers, 3 payload, EOP.
    do_reset();
    out_rdy = 1'b1;
    push_pkt(2, 0, 2, 3);
    build_expected(0);
    mon_en = 1'b1;
    apply();
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("q2_out_wr_c%0d", k), 72'(out_wr), 72'(k >= 2 && k <= 7));
      if (k == 1) check("q2_grant", 72'(grant), 72'd2);
      if (k == 6) check("q2_busy_mid", 72'(busy), 72'd1);
      if (k == 7) check("q2_busy_eop", 72'(busy), 72'd0);
    end
    check("q2_stream_done", 72'(exp_q.size()), 72'd0);
    push_pkt(0, 1, 1, 1);
    push_pkt(3, 1, 1, 1);
    build_expected(STRICT ? 0 : 3);
    apply();
    step();
    check("q2_next_grant", 72'(grant), STRICT ? 72'd0 : 72'd3);
    drain("q2_next_drain", 100);

    // Two packets in every queue.
    do_reset();
    out_rdy = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int q = 0; q < N; q++) push_pkt(q, p, 1 + q % 2, 2);
    end
    build_expected(0);
    mon_en = 1'b1;
    apply();
    drain("all_q_drain", 300);

    // Backpressure: out_rdy low in cycles 3..7 mid-payload.
    do_reset();
    push_pkt(1, 0, 1, 6);
    build_expected(0);
    mon_en = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      out_rdy = !(c >= 3 && c <= 7);
      apply();
      if (c >= 3 && c <= 7) check($sformatf("bp_rd_en_c%0d", c), 72'(in_rd_en), 72'd0);
      if (c >= 1) check($sformatf("bp_out_wr_c%0d", c), 72'(out_wr), 72'(c == 2 || c == 3 || c >= 9));
      step();
    end
    drain("bp_drain", 50);

    // Granted queue runs dry after its headers while q0 waits.
    do_reset();
    out_rdy = 1'b1;
    fifo_q[1].push_back(mk(8'hFF, 64'h1111_0000));
    fifo_q[1].push_back(mk(8'hFF, 64'h1111_0001));
    for (int i = 0; i < 2; i++) exp_q.push_back(fifo_q[1][i]);
    mon_en = 1'b1;
    apply();
    step();
    check("uf_grant_start", 72'(grant), 72'd1);
    push_pkt(0, 5, 1, 1);
    apply();
    for (int k = 0; k < 10; k++) begin
      step();
      check("uf_grant_hold", 72'(grant), 72'd1);
      check("uf_q0_not_popped", 72'(in_rd_en[0]), 72'd0);
      check("uf_busy", 72'(busy), 72'd1);
    end
    fifo_q[1].push_back(mk(8'h00, 64'h1111_0002));
    fifo_q[1].push_back(mk(8'h01, 64'h1111_0003));
    exp_q.push_back(mk(8'h00, 64'h1111_0002));
    exp_q.push_back(mk(8'h01, 64'h1111_0003));
    for (int i = 0; i < fifo_q[0].size(); i++) exp_q.push_back(fifo_q[0][i]);
    apply();
    drain("uf_drain", 50);

    // Reset in the middle of a q3 payload.
    do_reset();
    out_rdy = 1'b1;
    push_pkt(3, 0, 1, 8);
    apply();
    for (int k = 0; k < 4; k++) step();
    check("mr_popping", 72'(in_rd_en), 72'b1000);
    reset = 1'b1;
    step();
    check("mr_out_wr", 72'(out_wr), 72'd0);
    check("mr_grant", 72'(grant), 72'd0);
    check("mr_busy", 72'(busy), 72'd0);
    check("mr_out_data", 72'(out_data), 72'd0);
    check("mr_idle_no_pop", 72'(in_rd_en), 72'd0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) fifo_q[i].delete();
    push_pkt(0, 1, 1, 1);
    push_pkt(3, 1, 1, 1);
    build_expected(0);
    mon_en = 1'b1;
    apply();
    step();
    check("mr_restart_grant", 72'(grant), 72'd0);
    drain("mr_drain", 50);

    // Random packet mixes with random downstream readiness.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int q = 0; q < N; q++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          int nh;
          int npl;
          nh  = $urandom_range(1, 2);
          npl = $urandom_range(1, 4);
          for (int h = 0; h < nh; h++)
            fifo_q[q].push_back(mk(8'($urandom_range(1, 255)), {8'(q), 8'(p), 16'(h), 32'($urandom)}));
          for (int k = 0; k < npl; k++)
            fifo_q[q].push_back(mk(8'h00, {8'(q), 8'(p), 16'(nh + k), 32'($urandom)}));
          fifo_q[q].push_back(mk(8'($urandom_range(1, 255)), {8'(q), 8'(p), 16'hFFFF, 32'($urandom)}));
        end
      end
      build_expected(0);
      mon_en = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        out_rdy = ($urandom_range(0, 3) != 0);
        apply();
        check("rnd_onehot", 72'($onehot0(in_rd_en)), 72'd1);
        if (!out_rdy) check("rnd_rdy_gate", 72'(in_rd_en), 72'd0);
        step();
        n++;
      end
      check($sformatf("rnd%0d_drained", r), 72'(exp_q.size()), 72'd0);
      out_rdy = 1'b1;
      apply();
      step();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
